fir_seq_ctrl: RTL
=================

// Module: fir_seq_ctrl
// PURPOSE
//   Sequencer in front of the FIR core. On start it loads N coefficients from a host shadow bank
//   into the core's coefficient port, then streams samples into the core with valid/ready.
//   Results are returned on a valid/ready output stream through a credit-guarded result FIFO.
//   Sits between the bus/stream fabric and the FIR core, replacing direct host pokes.
// PARAMETERS
//   N          4   number of taps/coefficients (1..16)
//   DATA_WIDTH 16  sample, coefficient and result width
//   FIR_LAT    1   cycles from fir_valid_o high to matching fir_result_i valid (>=1)
//   FIFO_DEPTH 4   result FIFO entries; must be >= FIR_LAT+1
// PORTS
//   clk             in   1           clock, rising edge
//   rst_n           in   1           async reset, active-low
//   coef_wr_i       in   1           shadow bank write strobe
//   coef_idx_i      in   4           shadow bank index (>=N ignored)
//   coef_dat_i      in   DATA_WIDTH  shadow bank write data
//   start_i         in   1           pulse: load coefficients, then run
//   stop_i          in   1           pulse: stop accepting samples, drain, go idle
//   busy_o          out  1           state != IDLE
//   run_o           out  1           state == RUN
//   err_o           out  1           sticky readback mismatch (see CONFIGURATION)
//   s_valid_i/s_data_i[DATA_WIDTH]/s_ready_o   sample input stream
//   m_valid_o/m_data_o[DATA_WIDTH]/m_ready_i   result output stream
//   fir_valid_o     out  1           sample strobe to core
//   fir_sample_o    out  DATA_WIDTH  sample to core
//   fir_result_i    in   DATA_WIDTH  core result
//   fir_we_coeff_o  out  1           coefficient write enable to core
//   fir_addr_coeff_o out 4           coefficient address to core
//   fir_coeff_o     out  DATA_WIDTH  coefficient write data to core
//   fir_coeff_i     in   DATA_WIDTH  coefficient readback, valid 1 cycle after address
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, FIFO empty, in-flight count 0, err_o=0; shadow bank cleared to 0.
//   FSM: IDLE -start_i-> LOAD -> [VERIFY] -> RUN -stop_i-> DRAIN -(inflight==0 && FIFO empty)-> IDLE.
//   LOAD: one write per cycle, idx 0..N-1; fir_we_coeff_o=1 for exactly N cycles; then next state.
//   Shadow writes are accepted only in IDLE and RUN; ignored in LOAD/VERIFY/DRAIN.
//   start_i is ignored outside IDLE; stop_i is ignored outside RUN; both together in RUN: stop wins.
//   RUN: s_ready_o = (fifo_count + inflight) < FIFO_DEPTH. Sample handshake -> fir_valid_o=1,
//   fir_sample_o=s_data_i registered (1 cycle). A FIR_LAT-deep valid shift register marks when
//   fir_result_i is captured into the FIFO; the credit rule guarantees the FIFO never overflows.
//   DRAIN: s_ready_o=0; in-flight results still enter the FIFO; output keeps draining.
//   FIFO: m_valid_o = !empty; pop on m_valid_o&&m_ready_i; push and pop in the same cycle when full
//   is legal (count unchanged); data ordering is strictly FIFO; no drop at any boundary.
//   Throughput: 1 sample/cycle in RUN when m_ready_i is held high.
//   rst_n assertion mid-operation aborts any state immediately; a partial LOAD is not resumed.
// CONFIGURATION
//   FIR_SEQ_READBACK_EN defined: VERIFY state reads back idx 0..N-1 (addr cycle k, compare
//   fir_coeff_i in cycle k+1, N+1 cycles total); any mismatch sets err_o (sticky, cleared by
//   start_i) and FSM still enters RUN.
//   Not defined: LOAD goes directly to RUN; err_o tied 0; fir_coeff_i unused.
// STRUCTURE
//   Package fir_seq_pkg: FSM state encoding (IDLE, LOAD, VERIFY, RUN, DRAIN), ADDR_W=4,
//   CNT width helper function, FIFO_DEPTH>=FIR_LAT+1 parameter check.
//   Sub-module fir_seq_fifo: synchronous FIFO (DEPTH, WIDTH) with count output, reused for results.
// TESTING
//   Load h0001,h0002,h0003,h0004; start -> exactly 4 we cycles, addr 0..3 in order, run_o after.
//   RUN with m_ready_i=1: stream 1..8 -> 8 results in order, s_ready_o never drops.
//   m_ready_i=0: push until s_ready_o=0 after FIFO_DEPTH accepted; release -> all 4 results, no loss.
//   stop_i with 2 in flight -> DRAIN, both results emitted, then IDLE and busy_o=0.
//   READBACK_EN: core returns hFFFF on idx 2 -> err_o=1 and RUN entered; next start clears err_o.
//   rst_n low mid-LOAD (idx 1) -> all outputs 0 next edge, IDLE; start re-loads from idx 0.

Source files
------------

// File: rtl/fir_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_seq_pkg : shared types and helpers for the FIR sequencer               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fir_seq_pkg;

    localparam int ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

    // Bits needed to hold a count in the range 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic bit fifo_depth_ok(input int depth, input int lat);
        return (lat >= 1) && (depth >= lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_seq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_seq_fifo : synchronous FIFO with occupancy count                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fir_seq_fifo
    import fir_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == c_cw'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the same cycle frees an entry.
    assign w_do_push = push && (!w_full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_aw'(DEPTH - 1)) ? '0 : r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_aw'(DEPTH - 1)) ? '0 : r_rd_ptr + c_aw'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cw'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cw'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_seq_ctrl : coefficient loader and credit-guarded stream sequencer      |
// | for the FIR core. Optional readback check: define FIR_SEQ_READBACK_EN.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIR_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coef_wr_i,
    input  logic [ADDR_W-1:0]     coef_idx_i,
    input  logic [DATA_WIDTH-1:0] coef_dat_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  run_o,
    output logic                  err_o,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  fir_valid_o,
    output logic [DATA_WIDTH-1:0] fir_sample_o,
    input  logic [DATA_WIDTH-1:0] fir_result_i,
    output logic                  fir_we_coeff_o,
    output logic [ADDR_W-1:0]     fir_addr_coeff_o,
    output logic [DATA_WIDTH-1:0] fir_coeff_o,
    input  logic [DATA_WIDTH-1:0] fir_coeff_i
);

    localparam int             c_cw   = cnt_w(FIFO_DEPTH);
    localparam int             c_sw   = c_cw + 1;
    localparam logic [ADDR_W:0] c_last = (ADDR_W + 1)'(N - 1);
    localparam logic [ADDR_W:0] c_n    = (ADDR_W + 1)'(N);

    generate
        if (!fifo_depth_ok(FIFO_DEPTH, FIR_LAT) || N < 1 || N > 16) begin : g_bad_cfg
            $error("fir_seq_ctrl: need 1<=N<=16, FIR_LAT>=1, FIFO_DEPTH>=FIR_LAT+1");
        end
    endgenerate

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_W:0]       r_idx;
    logic [ADDR_W:0]       w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shadow [N];
    logic [DATA_WIDTH-1:0] w_shadow_rd;
    logic                  r_fir_valid;
    logic [DATA_WIDTH-1:0] r_fir_sample;
    logic [FIR_LAT-1:0]    r_vsr;
    logic [c_cw-1:0]       r_inflight;
    logic [c_cw-1:0]       w_fifo_count;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (r_idx == c_last) begin
`ifdef FIR_SEQ_READBACK_EN
                    w_state_nxt = ST_VERIFY;
`else
                    w_state_nxt = ST_RUN;
`endif
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + (ADDR_W + 1)'(1);
                end
            end
            ST_VERIFY: begin
                if (r_idx == c_n) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + (ADDR_W + 1)'(1);
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_inflight == '0 && w_fifo_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign busy_o           = (r_state != ST_IDLE);
    assign run_o            = (r_state == ST_RUN);
    assign fir_we_coeff_o   = (r_state == ST_LOAD);
    assign fir_addr_coeff_o = ((r_state == ST_LOAD) || (r_state == ST_VERIFY && r_idx < c_n))
                              ? r_idx[ADDR_W-1:0] : '0;
    assign fir_coeff_o      = (r_state == ST_LOAD) ? w_shadow_rd : '0;

    // ---------------- Shadow bank ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (coef_wr_i && (r_state == ST_IDLE || r_state == ST_RUN)) begin
            for (int i = 0; i < N; i++) begin
                if (coef_idx_i == ADDR_W'(i)) begin
                    r_shadow[i] <= coef_dat_i;
                end
            end
        end
    end

    always_comb begin
        w_shadow_rd = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == (ADDR_W + 1)'(i)) begin
                w_shadow_rd = r_shadow[i];
            end
        end
    end

    // ---------------- Sample path and credits ----------------
    // Every accepted sample owns a FIFO slot from acceptance until it is popped.
    assign s_ready_o = (r_state == ST_RUN) &&
                       ((c_sw'(w_fifo_count) + c_sw'(r_inflight)) < c_sw'(FIFO_DEPTH));
    assign w_accept  = s_valid_i && s_ready_o;
    assign w_push    = r_vsr[FIR_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fir_valid  <= 1'b0;
            r_fir_sample <= '0;
            r_inflight   <= '0;
        end else begin
            r_fir_valid <= w_accept;
            if (w_accept) begin
                r_fir_sample <= s_data_i;
            end
            if (w_accept && !w_push) begin
                r_inflight <= r_inflight + c_cw'(1);
            end else if (!w_accept && w_push) begin
                r_inflight <= r_inflight - c_cw'(1);
            end
        end
    end

    generate
        if (FIR_LAT == 1) begin : g_vsr_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= r_fir_valid;
                end
            end
        end else begin : g_vsr_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vsr <= '0;
                end else begin
                    r_vsr <= {r_vsr[FIR_LAT-2:0], r_fir_valid};
                end
            end
        end
    endgenerate

    assign fir_valid_o  = r_fir_valid;
    assign fir_sample_o = r_fir_sample;

    // ---------------- Result FIFO ----------------
    assign w_pop     = m_valid_o && m_ready_i;
    assign m_valid_o = !w_fifo_empty;
    assign m_data_o  = m_valid_o ? w_fifo_data : '0;

    fir_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (fir_result_i),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // ---------------- Coefficient readback ----------------
`ifdef FIR_SEQ_READBACK_EN
    logic                  r_err;
    logic [DATA_WIDTH-1:0] w_shadow_prev;
    logic                  w_mismatch;

    // Readback lags the address by one cycle, so cycle k checks entry k-1.
    always_comb begin
        w_shadow_prev = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == (ADDR_W + 1)'(i + 1)) begin
                w_shadow_prev = r_shadow[i];
            end
        end
    end

    assign w_mismatch = (r_state == ST_VERIFY) && (r_idx != '0) && (fir_coeff_i != w_shadow_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && start_i) begin
            r_err <= 1'b0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_coeff;
    assign w_unused_coeff = ^fir_coeff_i;
    assign err_o          = 1'b0;
`endif

endmodule
`default_nettype wire
